exe_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one exe_unit (8-bit args, 4-bit opcode, 8-bit result, 4 flags) among R independent requesters.
- Each requester hands over an operation {argA, argB, oper} on a valid/ready request channel.
- The block registers the operands into the exe_unit inputs and captures result and flags one cycle later. It returns them on a valid/ready response channel to the granted requester only.
- It sits between SPI front-ends (or other masters) and a single exe_unit instance.

---
 rtl/exe_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/exe_arbiter.sv | 108 ++++++++++
 tb/tb_exe_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_arb_pkg.sv
// Shared types and constants for the exe_unit arbiter slice.
package exe_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Flag bit positions within the 4-bit {OF,SF,ZF,PF} vector
  localparam int unsigned FlagPf = 0;
  localparam int unsigned FlagZf = 1;
  localparam int unsigned FlagSf = 2;
  localparam int unsigned FlagOf = 3;

  localparam int unsigned DefM = 8;
  localparam int unsigned DefN = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or after i_ptr wins.
module rr_arbiter #(
  parameter  int unsigned R   = 4,
  localparam int unsigned IdW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]   i_req,
  input  logic [IdW-1:0] i_ptr,
  input  logic           i_en,
  output logic [R-1:0]   o_gnt,
  output logic [IdW-1:0] o_gnt_id,
  output logic           o_any
);

  logic           found;
  logic [IdW-1:0] idx;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < R; i++) begin
      idx = IdW'((32'(i_ptr) + i) % R);
      if (i_en && !found && i_req[idx]) begin
        found       = 1'b1;
        o_gnt[idx]  = 1'b1;
        o_gnt_id    = idx;
      end
    end
  end

  assign o_any = found;

endmodule

// File: rtl/exe_arbiter.sv
// Round-robin sequencer sharing one exe_unit among R requesters: accept, execute, respond.
module exe_arbiter
  import exe_arb_pkg::*;
#(
  parameter  int unsigned R   = 4,
  parameter  int unsigned M   = DefM,
  parameter  int unsigned N   = DefN,
  localparam int unsigned IdW = (R > 1) ? $clog2(R) : 1
) (
  input  logic           i_clk_p,
  input  logic           i_rst,
  input  logic [R-1:0]   i_req_valid,
  output logic [R-1:0]   o_req_ready,
  input  logic [R*M-1:0] i_argA,
  input  logic [R*M-1:0] i_argB,
  input  logic [R*N-1:0] i_oper,
  output logic [R-1:0]   o_rsp_valid,
  input  logic [R-1:0]   i_rsp_ready,
  output logic [M-1:0]   o_result,
  output logic [3:0]     o_flags,
  output logic [IdW-1:0] o_grant_id,
  output logic           o_busy,
  output logic [M-1:0]   o_exe_argA,
  output logic [M-1:0]   o_exe_argB,
  output logic [N-1:0]   o_exe_oper,
  input  logic [M-1:0]   i_exe_result,
  input  logic [3:0]     i_exe_flags
);

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, grant_q, ptr_next;
  logic [M-1:0]   arg_a_q, arg_b_q, result_q;
  logic [N-1:0]   oper_q;
  logic [3:0]     flags_q;

  logic [R-1:0]   gnt;
  logic [IdW-1:0] gnt_id;
  logic           gnt_any;
  logic           rsp_accept;

  // Ready must stay low while reset is being applied, even though state is IDLE
  rr_arbiter #(
    .R (R)
  ) u_rr (
    .i_req    (i_req_valid),
    .i_ptr    (ptr_q),
    .i_en     ((state_q == StIdle) && !i_rst),
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id),
    .o_any    (gnt_any)
  );

  assign ptr_next = (grant_q == IdW'(R - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rsp_accept  = 1'b0;
    o_rsp_valid = '0;
    case (state_q)
      StIdle: if (gnt_any) state_d = StExec;
      StExec: state_d = StResp;
      StResp: begin
        o_rsp_valid[grant_q] = 1'b1;
        if (i_rsp_ready[grant_q]) begin
          rsp_accept = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      arg_a_q  <= '0;
      arg_b_q  <= '0;
      oper_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && gnt_any) begin
        arg_a_q <= i_argA[gnt_id*M +: M];
        arg_b_q <= i_argB[gnt_id*M +: M];
        oper_q  <= i_oper[gnt_id*N +: N];
        grant_q <= gnt_id;
      end
      if (state_q == StExec) begin
        result_q <= i_exe_result;
        flags_q  <= i_exe_flags;
      end
      if (rsp_accept) ptr_q <= ptr_next;
    end
  end

  assign o_req_ready = gnt;
  assign o_busy      = (state_q != StIdle);
  assign o_grant_id  = grant_q;
  assign o_exe_argA  = arg_a_q;
  assign o_exe_argB  = arg_b_q;
  assign o_exe_oper  = oper_q;
  assign o_result    = result_q;
  assign o_flags     = flags_q;

endmodule

// File: tb/tb_exe_arbiter.sv
// Bench for exe_arbiter: directed scenarios then random traffic against a cycle reference model.
module tb_exe_arbiter;

  localparam int unsigned R   = 4;
  localparam int unsigned M   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IdW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [R*M-1:0] arg_a, arg_b;
  logic [R*N-1:0] oper;
  logic [M-1:0]   result, exe_a, exe_b, exe_result;
  logic [3:0]     flags, exe_flags;
  logic [N-1:0]   exe_oper;
  logic [IdW-1:0] grant_id;
  logic           busy;

  always #5 clk = ~clk;

  exe_arbiter #(
    .R (R),
    .M (M),
    .N (N)
  ) dut (
    .i_clk_p      (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_argA       (arg_a),
    .i_argB       (arg_b),
    .i_oper       (oper),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_result     (result),
    .o_flags      (flags),
    .o_grant_id   (grant_id),
    .o_busy       (busy),
    .o_exe_argA   (exe_a),
    .o_exe_argB   (exe_b),
    .o_exe_oper   (exe_oper),
    .i_exe_result (exe_result),
    .i_exe_flags  (exe_flags)
  );

  // exe_unit stand-in: add, flags {carry, sign, zero, even parity}
  function automatic logic [11:0] ref_exe(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[M], s[M-1], (s[M-1:0] == '0), ~^s[M-1:0], s[M-1:0]};
  endfunction

  assign {exe_flags, exe_result} = ref_exe(exe_a, exe_b);

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 idle, 1 executing, 2 responding
  int           m_ph = 0, m_ptr = 0, m_gid = 0;
  logic [M-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [N-1:0] m_op = '0;
  logic [3:0]   m_flg = '0;
  int           acc_id, done_id;

  logic [R-1:0] seen_ready, seen_rv;
  logic [M-1:0] seen_res;
  logic [3:0]   seen_flg;
  logic         seen_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [R-1:0] v, input int p);
    for (int i = 0; i < R; i++) if (v[IdW'((p + i) % R)]) return (p + i) % R;
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [M-1:0] a, input logic [M-1:0] b,
                         input logic [N-1:0] op);
    arg_a[k*M +: M] = a;
    arg_b[k*M +: M] = b;
    oper[k*N +: N]  = op;
  endtask

  // Inputs are held from posedge+1 through the next posedge; outputs sampled at negedge.
  task automatic cycle();
    logic [R-1:0] e_ready, e_rv;
    logic [11:0]  ef;
    int           g;
    @(negedge clk);
    cyc++;
    g = (!rst && m_ph == 0) ? pick(req_valid, m_ptr) : -1;
    e_ready = '0;
    if (g >= 0) e_ready[IdW'(g)] = 1'b1;
    e_rv = '0;
    if (m_ph == 2) e_rv[IdW'(m_gid)] = 1'b1;
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("busy", 32'(busy), 32'(m_ph != 0));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("exe_argA", 32'(exe_a), 32'(m_a));
      check("exe_argB", 32'(exe_b), 32'(m_b));
      check("exe_oper", 32'(exe_oper), 32'(m_op));
      check("result", 32'(result), 32'(m_res));
      check("flags", 32'(flags), 32'(m_flg));
    end
    seen_ready = req_ready;
    seen_rv    = rsp_valid;
    seen_res   = result;
    seen_flg   = flags;
    seen_busy  = busy;
    acc_id     = -1;
    done_id    = -1;
    if (rst) begin
      m_ph = 0; m_ptr = 0; m_gid = 0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = '0;
    end else if (m_ph == 0) begin
      if (g >= 0) begin
        m_a = arg_a[g*M +: M]; m_b = arg_b[g*M +: M]; m_op = oper[g*N +: N];
        m_gid = g; m_ph = 1; acc_id = g;
      end
    end else if (m_ph == 1) begin
      ef = ref_exe(m_a, m_b);
      m_res = ef[M-1:0]; m_flg = ef[11:8]; m_ph = 2;
    end else if (rsp_ready[IdW'(m_gid)]) begin
      m_ptr = (m_gid + 1) % R; m_ph = 0; done_id = m_gid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < 8 && m_ph != 0; i++) cycle();
    check("drain_idle", 32'(busy), 32'(0));
  endtask

  int rr_gid[$];
  int rr_cyc[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    for (int k = 0; k < R; k++) set_req(k, M'($urandom), M'($urandom), N'($urandom));
    set_req(0, 8'h05, 8'h03, 4'h2);
    @(posedge clk);
    #1;

    // Reset with all requests valid
    cycle();
    chk_en = 1'b1;
    cycle();
    check("rst_ready", 32'(seen_ready), 32'(0));
    check("rst_busy", 32'(seen_busy), 32'(0));

    // Round-robin with everyone valid and immediate response ready
    rst = 1'b0;
    rsp_ready = '1;
    cycle();
    check("first_grant", 32'(seen_ready), 32'(4'b0001));
    for (int i = 0; i < 20 && rr_gid.size() < 5; i++) begin
      cycle();
      if (seen_rv != '0) begin
        if (rr_gid.size() == 0) check("rr_first_result", 32'(seen_res), 32'(8'h08));
        rr_gid.push_back(pick(seen_rv, 0));
        rr_cyc.push_back(cyc);
      end
    end
    check("rr_count", 32'(rr_gid.size()), 32'(5));
    for (int i = 0; i < rr_gid.size() && i < 5; i++) begin
      check("rr_order", 32'(rr_gid[i]), 32'(exp_order[i]));
      if (i > 0) check("rr_spacing", 32'(rr_cyc[i] - rr_cyc[i-1]), 32'(3));
    end
    drain();

    // Single op from R2
    set_req(2, 8'h12, 8'h34, 4'h1);
    req_valid = 4'b0100;
    rsp_ready = '0;
    cycle();
    check("single_ready", 32'(seen_ready), 32'(4'b0100));
    req_valid = '0;
    cycle();
    cycle();
    check("single_rv", 32'(seen_rv), 32'(4'b0100));
    check("single_result", 32'(seen_res), 32'(8'h46));
    check("single_flags", 32'(seen_flg), 32'(4'h0));
    rsp_ready = 4'b0100;
    cycle();
    rsp_ready = '0;
    cycle();
    check("single_idle", 32'(seen_busy), 32'(0));

    // Backpressure on R1 with R3 waiting, then wrong-ready
    set_req(1, 8'hF0, 8'h20, 4'h5);
    set_req(3, 8'h01, 8'h01, 4'h7);
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b1000;
    cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("bp_rv", 32'(seen_rv), 32'(4'b0010));
      check("bp_result", 32'(seen_res), 32'(8'h10));
      check("bp_flags", 32'(seen_flg), 32'(4'h8));
      check("bp_ready", 32'(seen_ready), 32'(0));
    end
    rsp_ready = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("wrong_ready_rv", 32'(seen_rv), 32'(4'b0010));
    end
    rsp_ready = 4'b0010;
    cycle();
    rsp_ready = '0;
    cycle();
    check("bp_next_grant", 32'(seen_ready), 32'(4'b1000));
    drain();

    // Reset while R1 is responding; ptr returns to 0
    set_req(1, 8'h80, 8'h80, 4'h3);
    req_valid = 4'b0010;
    rsp_ready = '0;
    cycle();
    req_valid = 4'b0101;
    cycle();
    cycle();
    check("midop_flags", 32'(seen_flg), 32'(4'hB));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("midop_rv", 32'(seen_rv), 32'(0));
    check("midop_grant", 32'(seen_ready), 32'(4'b0001));
    check("midop_result_clr", 32'(seen_res), 32'(0));
    drain();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < R; k++) begin
        if (!req_valid[k] && $urandom_range(2) == 0) begin
          set_req(k, M'($urandom), M'($urandom), N'($urandom));
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = R'($urandom);
      rst = ($urandom_range(199) == 0);
      cycle();
      if (acc_id >= 0) req_valid[acc_id] = 1'b0;
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
